// File: rtl/mul_add_pkg.sv
// Shared widths, saturation limits and the accumulator-to-pixel clamp
// for the nine-tap multiply-accumulate engine.
package mul_add_pkg;

  localparam int DATA_W = 17;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam int TAPS   = 9;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 17'sh0FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 17'sh10000;

  // Limits at accumulator width so the comparisons stay fully signed.
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = ACC_W'(SAT_MIN);

  function automatic logic signed [DATA_W-1:0] sat_to_data(
    input logic signed [ACC_W-1:0] acc
  );
    if (acc > ACC_SAT_MAX)      return SAT_MAX;
    else if (acc < ACC_SAT_MIN) return SAT_MIN;
    else                        return acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mul_add_lane.sv
// One tap of the kernel: a full-width signed multiply feeding an
// enabled, asynchronously cleared product register.
module mul_add_lane
  import mul_add_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] pixel,
  output logic signed [PROD_W-1:0] prod
);

  // Widen before multiplying so the product keeps all 34 bits.
  logic signed [PROD_W-1:0] prod_next;
  assign prod_next = PROD_W'(weight) * PROD_W'(pixel);

  // NOTE: non-blocking assignment keeps every register sampling the
  // pre-edge values, so the lanes and the output stage stay in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     prod <= '0;
    else if (en) prod <= prod_next;
  end

endmodule

// File: rtl/mul_add.sv
// Nine-tap signed dot product: registered products, a combinational adder
// tree with saturation, and a registered output pixel.
module mul_add
  import mul_add_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] kernel_weights0,
  input  logic signed [DATA_W-1:0] kernel_weights1,
  input  logic signed [DATA_W-1:0] kernel_weights2,
  input  logic signed [DATA_W-1:0] kernel_weights3,
  input  logic signed [DATA_W-1:0] kernel_weights4,
  input  logic signed [DATA_W-1:0] kernel_weights5,
  input  logic signed [DATA_W-1:0] kernel_weights6,
  input  logic signed [DATA_W-1:0] kernel_weights7,
  input  logic signed [DATA_W-1:0] kernel_weights8,
  input  logic signed [DATA_W-1:0] subimage0,
  input  logic signed [DATA_W-1:0] subimage1,
  input  logic signed [DATA_W-1:0] subimage2,
  input  logic signed [DATA_W-1:0] subimage3,
  input  logic signed [DATA_W-1:0] subimage4,
  input  logic signed [DATA_W-1:0] subimage5,
  input  logic signed [DATA_W-1:0] subimage6,
  input  logic signed [DATA_W-1:0] subimage7,
  input  logic signed [DATA_W-1:0] subimage8,
  output logic signed [DATA_W-1:0] out_pix
);

  logic signed [DATA_W-1:0] weight [TAPS];
  logic signed [DATA_W-1:0] pixel  [TAPS];
  logic signed [PROD_W-1:0] prod   [TAPS];

  assign weight[0] = kernel_weights0;
  assign weight[1] = kernel_weights1;
  assign weight[2] = kernel_weights2;
  assign weight[3] = kernel_weights3;
  assign weight[4] = kernel_weights4;
  assign weight[5] = kernel_weights5;
  assign weight[6] = kernel_weights6;
  assign weight[7] = kernel_weights7;
  assign weight[8] = kernel_weights8;

  assign pixel[0] = subimage0;
  assign pixel[1] = subimage1;
  assign pixel[2] = subimage2;
  assign pixel[3] = subimage3;
  assign pixel[4] = subimage4;
  assign pixel[5] = subimage5;
  assign pixel[6] = subimage6;
  assign pixel[7] = subimage7;
  assign pixel[8] = subimage8;

  for (genvar i = 0; i < TAPS; i++) begin : g_lane
    mul_add_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .weight (weight[i]),
      .pixel  (pixel[i]),
      .prod   (prod[i])
    );
  end

  // Sign-extend each product so nine worst-case terms cannot overflow.
  logic signed [ACC_W-1:0] prod_ext [TAPS];
  for (genvar i = 0; i < TAPS; i++) begin : g_ext
    assign prod_ext[i] = ACC_W'(prod[i]);
  end

  logic signed [ACC_W-1:0] lvl1 [4];
  logic signed [ACC_W-1:0] lvl2 [2];
  logic signed [ACC_W-1:0] acc;

  assign lvl1[0] = prod_ext[0] + prod_ext[1];
  assign lvl1[1] = prod_ext[2] + prod_ext[3];
  assign lvl1[2] = prod_ext[4] + prod_ext[5];
  assign lvl1[3] = prod_ext[6] + prod_ext[7];
  assign lvl2[0] = lvl1[0] + lvl1[1];
  assign lvl2[1] = lvl1[2] + lvl1[3];
  assign acc     = lvl2[0] + lvl2[1] + prod_ext[8];

  // NOTE: the output register is cleared by the asynchronous reset like the
  // product registers, so a reset discards everything in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     out_pix <= '0;
    else if (en) out_pix <= sat_to_data(acc);
  end

endmodule

// File: tb/tb_mul_add.sv
// Self-checking bench for mul_add: vector table through a scoreboard plus
// hand-written stall and reset sequences.
module tb_mul_add;

  localparam int W = 17;

  typedef struct {
    logic [8:0][W-1:0] w;
    logic [8:0][W-1:0] s;
    logic signed [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic signed [W-1:0] w [9];
  logic signed [W-1:0] s [9];
  logic signed [W-1:0] out_pix;

  int checks = 0;
  int errors = 0;

  vec_t tbl [$];
  logic signed [W-1:0] sb [$];

  always #5 clk = ~clk;

  mul_add dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .kernel_weights0 (w[0]),
    .kernel_weights1 (w[1]),
    .kernel_weights2 (w[2]),
    .kernel_weights3 (w[3]),
    .kernel_weights4 (w[4]),
    .kernel_weights5 (w[5]),
    .kernel_weights6 (w[6]),
    .kernel_weights7 (w[7]),
    .kernel_weights8 (w[8]),
    .subimage0       (s[0]),
    .subimage1       (s[1]),
    .subimage2       (s[2]),
    .subimage3       (s[3]),
    .subimage4       (s[4]),
    .subimage5       (s[5]),
    .subimage6       (s[6]),
    .subimage7       (s[7]),
    .subimage8       (s[8]),
    .out_pix         (out_pix)
  );

  task automatic check(input string name, input logic signed [W-1:0] act,
                       input logic signed [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: out_pix=%0d (17'h%05h) expected %0d (17'h%05h)",
               name, act, act, req, req);
    end
  endtask

  // Reference dot product at 64-bit width, then clamped to pixel range.
  function automatic logic signed [W-1:0] model(input vec_t v);
    longint acc = 0;
    for (int i = 0; i < 9; i++)
      acc += longint'($signed(v.w[i])) * longint'($signed(v.s[i]));
    if (acc > 65535)       return 17'sh0FFFF;
    else if (acc < -65536) return 17'sh10000;
    else                   return W'(acc);
  endfunction

  function automatic vec_t zero_vec();
    vec_t v;
    v.w = '0;
    v.s = '0;
    v.exp = '0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    for (int i = 0; i < 9; i++) begin
      w[i] = $signed(v.w[i]);
      s[i] = $signed(v.s[i]);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t v, basic, signed_v, sat_hi;
  logic signed [W-1:0] exp_v;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    drive(zero_vec());

    // Named patterns used by the table and the hand-written sequences.
    basic = zero_vec();
    basic.w[0] = 17'd2;  basic.s[0] = 17'd3;
    basic.w[1] = 17'd1;  basic.s[1] = 17'd6;
    basic.exp = 17'sd12;

    signed_v = zero_vec();
    signed_v.w[0] = -17'sd2; signed_v.s[0] = 17'sd3;
    signed_v.w[4] = 17'sd5;  signed_v.s[4] = -17'sd4;
    signed_v.exp = -17'sd26;

    sat_hi = zero_vec();
    for (int i = 0; i < 9; i++) begin
      sat_hi.w[i] = 17'h0FFFF;
      sat_hi.s[i] = 17'h0FFFF;
    end
    sat_hi.exp = 17'sh0FFFF;

    tbl.push_back(basic);
    v = zero_vec(); tbl.push_back(v);
    tbl.push_back(signed_v);
    tbl.push_back(sat_hi);
    v = sat_hi;
    for (int i = 0; i < 9; i++) v.w[i] = 17'h10000;
    v.exp = 17'sh10000; tbl.push_back(v);
    // All taps at the most negative value: largest positive sum.
    for (int i = 0; i < 9; i++) v.s[i] = 17'h10000;
    v.exp = 17'sh0FFFF; tbl.push_back(v);
    v = zero_vec();
    for (int i = 0; i < 9; i++) begin
      v.w[i] = 17'd1;
      v.s[i] = W'(i + 1);
    end
    v.exp = 17'sd45; tbl.push_back(v);
    v = zero_vec(); v.w[8] = 17'd1000; v.s[8] = -17'sd3;
    v.exp = -17'sd3000; tbl.push_back(v);
    v = zero_vec(); v.w[0] = 17'h0FFFF; v.s[0] = 17'd1;
    v.exp = 17'sh0FFFF; tbl.push_back(v);
    v.w[1] = 17'd1; v.s[1] = 17'd1;
    v.exp = 17'sh0FFFF; tbl.push_back(v);
    v = zero_vec(); v.w[0] = 17'h10000; v.s[0] = 17'd1;
    v.exp = 17'sh10000; tbl.push_back(v);
    v.w[1] = -17'sd1; v.s[1] = 17'd1;
    v.exp = 17'sh10000; tbl.push_back(v);
    v = zero_vec(); v.w[3] = 17'd300; v.s[3] = 17'd200;
    v.w[7] = -17'sd100; v.s[7] = 17'd50;
    v.exp = 17'sd55000; tbl.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = zero_vec();
      for (int i = 0; i < 9; i++) begin
        v.w[i] = W'($urandom_range(0, 17'h1FFFF) >> (k % 3) * 4);
        v.s[i] = W'($urandom_range(0, 17'h1FFFF) >> (k % 3) * 3);
        if (k[0]) v.s[i] = W'($signed(v.s[i]) >>> 8);
      end
      v.exp = model(v);
      tbl.push_back(v);
    end

    // Reset state.
    #2;
    check("reset_async", out_pix, 17'sd0);
    tick();
    check("reset_held", out_pix, 17'sd0);
    rst = 1'b0;

    // Basic: zero after the first enabled edge, 12 after the second, then holds.
    en = 1'b1;
    drive(basic);
    tick(); check("basic_edge1", out_pix, 17'sd0);
    tick(); check("basic_edge2", out_pix, 17'sd12);
    tick(); check("basic_hold", out_pix, 17'sd12);

    // Back-to-back table through the scoreboard.
    do_reset();
    en = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      tick();
      if (sb.size() >= 2) begin
        exp_v = sb.pop_front();
        check($sformatf("vec%0d", i - 1), out_pix, exp_v);
      end
    end
    drive(zero_vec());
    sb.push_back(17'sd0);
    tick();
    exp_v = sb.pop_front();
    check($sformatf("vec%0d", tbl.size() - 1), out_pix, exp_v);

    // Stall: out_pix shows -26, stage 1 holds the basic pattern.
    do_reset();
    en = 1'b1;
    drive(signed_v);
    tick(); tick();
    check("stall_pre", out_pix, -17'sd26);
    drive(basic);
    tick();
    check("stall_load", out_pix, -17'sd26);
    en = 1'b0;
    drive(sat_hi);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_hold%0d", k), out_pix, -17'sd26);
    end
    en = 1'b1;
    tick(); check("stall_resume", out_pix, 17'sd12);
    tick(); check("stall_next", out_pix, 17'sh0FFFF);

    // Reset mid-pipeline, asserted between edges.
    drive(basic);
    tick(); tick();
    check("midrst_pre", out_pix, 17'sd12);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async", out_pix, 17'sd0);
    tick();
    check("midrst_held", out_pix, 17'sd0);
    rst = 1'b0;
    tick(); check("midrst_edge1", out_pix, 17'sd0);
    tick(); check("midrst_edge2", out_pix, 17'sd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
